// File: rtl/axi_bus_pkg.sv
// Shared AXI B-channel layout: field widths, packed-word offsets, response codes
// and the skid-buffer occupancy encoding.
package axi_bus_pkg;

  localparam int ID_W   = 8;
  localparam int RESP_W = 2;
  localparam int USER_W = 4;
  localparam int PACK_W = ID_W + RESP_W + USER_W;

  localparam int BID_LSB   = 6;
  localparam int BRESP_LSB = 4;
  localparam int BUSER_LSB = 0;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'b00,
    OCC_ONE   = 2'b01,
    OCC_TWO   = 2'b10
  } occ_e;

  // SLVERR and DECERR both carry bit 1; OKAY/EXOKAY do not.
  function automatic logic is_err_resp(input logic [1:0] resp);
    return resp[1];
  endfunction

endpackage

// File: rtl/axi_skid_buffer.sv
// Two-entry skid buffer with registered in_ready/out_valid; main drives the
// output, skid catches the word accepted while main is stalled.
module axi_skid_buffer
  import axi_bus_pkg::*;
#(
  parameter int W = 14
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  occ_e         state_q, state_d;
  logic         ready_q, ready_d;
  logic         valid_q, valid_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         accept_s;
  logic         deliver_s;

  assign accept_s  = in_valid && ready_q;
  assign deliver_s = valid_q && out_ready;

  // State and storage registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= OCC_EMPTY;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // Next occupancy
  always_comb begin
    state_d = state_q;
    case (state_q)
      OCC_EMPTY: begin
        if (accept_s) state_d = OCC_ONE;
        else          state_d = OCC_EMPTY;
      end
      OCC_ONE: begin
        if (accept_s && !deliver_s)      state_d = OCC_TWO;
        else if (!accept_s && deliver_s) state_d = OCC_EMPTY;
        else                             state_d = OCC_ONE;
      end
      OCC_TWO: begin
        if (deliver_s) state_d = OCC_ONE;
        else           state_d = OCC_TWO;
      end
      default: state_d = OCC_EMPTY;
    endcase
  end

  // Handshake flags and data movement for the coming edge
  always_comb begin
    ready_d = (state_d != OCC_TWO);
    valid_d = (state_d != OCC_EMPTY);
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      OCC_EMPTY: begin
        if (accept_s) main_d = in_data;
        else          main_d = main_q;
      end
      OCC_ONE: begin
        if (accept_s && deliver_s) main_d = in_data;
        else if (accept_s)         skid_d = in_data;
        else                       main_d = main_q;
      end
      OCC_TWO: begin
        if (deliver_s) main_d = skid_q;
        else           main_d = main_q;
      end
      default: begin
        main_d = main_q;
        skid_d = skid_q;
      end
    endcase
  end

  assign in_ready  = ready_q;
  assign out_valid = valid_q;
  assign out_data  = main_q;

endmodule

// File: rtl/w_backward_splitter.sv
// Restores the AXI4 B channel from the packed response word and counts
// delivered error responses with a saturating counter.
module w_backward_splitter #(
  parameter int ID_W   = 8,
  parameter int RESP_W = 2,
  parameter int USER_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic                       ACLK,
  input  logic                       ARESETn,
  input  logic [ID_W+RESP_W+USER_W-1:0] DATA,
  input  logic                       VALID,
  output logic                       READY,
  output logic [ID_W-1:0]            BID,
  output logic [RESP_W-1:0]          BRESP,
  output logic [USER_W-1:0]          BUSER,
  output logic                       BVALID,
  input  logic                       BREADY,
  output logic [CNT_W-1:0]           ERR_CNT,
  input  logic                       ERR_CLR
);

  import axi_bus_pkg::*;

  localparam int W = ID_W + RESP_W + USER_W;

  logic [W-1:0]     word_s;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  axi_skid_buffer #(.W(W)) u_skid (
    .clk       (ACLK),
    .rst_n     (ARESETn),
    .in_data   (DATA),
    .in_valid  (VALID),
    .in_ready  (READY),
    .out_data  (word_s),
    .out_valid (BVALID),
    .out_ready (BREADY)
  );

  assign BID   = word_s[BID_LSB   +: ID_W];
  assign BRESP = word_s[BRESP_LSB +: RESP_W];
  assign BUSER = word_s[BUSER_LSB +: USER_W];

  // Error counter register
  always_ff @(posedge ACLK) begin
    if (!ARESETn) err_cnt_q <= '0;
    else          err_cnt_q <= err_cnt_d;
  end

  // Clear wins over a same-cycle increment; saturate at all-ones
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (ERR_CLR) begin
      err_cnt_d = '0;
    end else if (BVALID && BREADY && is_err_resp(BRESP[1:0]) &&
                 (err_cnt_q != {CNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  assign ERR_CNT = err_cnt_q;

endmodule

// File: tb/tb_w_backward_splitter.sv
// Directed bench: two splitter instances (16-bit and 4-bit error counters)
// share one stimulus stream.
module tb_w_backward_splitter;

  logic        aclk;
  logic        aresetn;
  logic [13:0] data;
  logic        valid;
  logic        bready;
  logic        err_clr;

  logic        ready,  ready4;
  logic [7:0]  bid,    bid4;
  logic [1:0]  bresp,  bresp4;
  logic [3:0]  buser,  buser4;
  logic        bvalid, bvalid4;
  logic [15:0] err_cnt;
  logic [3:0]  err_cnt4;

  int checks   = 0;
  int failures = 0;

  w_backward_splitter dut (
    .ACLK(aclk), .ARESETn(aresetn), .DATA(data), .VALID(valid), .READY(ready),
    .BID(bid), .BRESP(bresp), .BUSER(buser), .BVALID(bvalid), .BREADY(bready),
    .ERR_CNT(err_cnt), .ERR_CLR(err_clr)
  );

  w_backward_splitter #(.CNT_W(4)) dut4 (
    .ACLK(aclk), .ARESETn(aresetn), .DATA(data), .VALID(valid), .READY(ready4),
    .BID(bid4), .BRESP(bresp4), .BUSER(buser4), .BVALID(bvalid4), .BREADY(bready),
    .ERR_CNT(err_cnt4), .ERR_CLR(err_clr)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected outputs for a word sitting in the output register
  task automatic check_word(input string tag, input logic [13:0] w);
    check({tag, ".bvalid"}, {31'd0, bvalid}, 32'd1);
    check({tag, ".bid"},    {24'd0, bid},    {24'd0, w[13:6]});
    check({tag, ".bresp"},  {30'd0, bresp},  {30'd0, w[5:4]});
    check({tag, ".buser"},  {28'd0, buser},  {28'd0, w[3:0]});
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  function automatic logic [13:0] mk(input logic [7:0] id, input logic [1:0] r, input logic [3:0] u);
    return {id, r, u};
  endfunction

  initial begin
    aresetn = 1'b0; data = 14'd0; valid = 1'b0; bready = 1'b0; err_clr = 1'b0;
    step(); step();
    check("rst.ready",  {31'd0, ready},   32'd0);
    check("rst.bvalid", {31'd0, bvalid},  32'd0);
    check("rst.bid",    {24'd0, bid},     32'd0);
    check("rst.errcnt", {16'd0, err_cnt}, 32'd0);

    aresetn = 1'b1;
    step();
    check("post_rst.ready",  {31'd0, ready},  32'd1);
    check("post_rst.bvalid", {31'd0, bvalid}, 32'd0);

    // single word
    data = mk(8'hA5, 2'b00, 4'h3); valid = 1'b1; bready = 1'b1;
    step();
    check("single.bvalid", {31'd0, bvalid}, 32'd1);
    check("single.bid",    {24'd0, bid},    32'h0000_00A5);
    check("single.bresp",  {30'd0, bresp},  32'd0);
    check("single.buser",  {28'd0, buser},  32'd3);
    valid = 1'b0;
    step();
    check("single.drop",   {31'd0, bvalid},  32'd0);
    check("single.errcnt", {16'd0, err_cnt}, 32'd0);

    // backpressure
    bready = 1'b0; valid = 1'b1; data = 14'h1001;
    step();
    check_word("bp.w1", 14'h1001);
    check("bp.ready1", {31'd0, ready}, 32'd1);
    data = 14'h1002;
    step();
    check("bp.ready2", {31'd0, ready}, 32'd0);
    check_word("bp.hold_a", 14'h1001);
    data = 14'h1003;
    step();
    check("bp.ready3", {31'd0, ready}, 32'd0);
    check_word("bp.hold_b", 14'h1001);
    valid = 1'bx; data = 14'bx;
    step();
    check("bp.xready", {31'd0, ready}, 32'd0);
    check_word("bp.xhold", 14'h1001);
    valid = 1'b1; data = 14'h1003;
    step();
    check_word("bp.hold_c", 14'h1001);
    bready = 1'b1;
    step();
    check_word("bp.out2", 14'h1002);
    check("bp.ready4", {31'd0, ready}, 32'd1);
    step();
    check_word("bp.out3", 14'h1003);
    valid = 1'b0;
    step();
    check("bp.empty", {31'd0, bvalid}, 32'd0);
    check("bp.errcnt", {16'd0, err_cnt}, 32'd0);

    // streaming, OKAY responses only
    valid = 1'b1; bready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      data = mk(i[7:0], 2'b00, i[3:0]);
      step();
      check_word("stream", mk(i[7:0], 2'b00, i[3:0]));
    end
    valid = 1'b0;
    step();
    check("stream.end",    {31'd0, bvalid},  32'd0);
    check("stream.errcnt", {16'd0, err_cnt}, 32'd0);

    // error counting: 0,1,2,3,2 -> 3
    valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      data = mk(8'h40 + i[7:0], (i == 4) ? 2'b10 : i[1:0], 4'h0);
      step();
    end
    valid = 1'b0;
    step();
    check("err.cnt",  {16'd0, err_cnt}, 32'd3);
    check("err.cnt4", {28'd0, err_cnt4}, 32'd3);
    valid = 1'b1; data = mk(8'h55, 2'b10, 4'h0);
    step();
    valid = 1'b0; err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("err.clr", {16'd0, err_cnt}, 32'd0);
    check("err.clr_bvalid", {31'd0, bvalid}, 32'd0);

    // saturation: 20 DECERR
    valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      data = mk(i[7:0], 2'b11, 4'h0);
      step();
    end
    valid = 1'b0;
    step();
    check("sat.cnt4", {28'd0, err_cnt4}, 32'hF);
    check("sat.cnt16", {16'd0, err_cnt}, 32'd20);
    valid = 1'b1; data = mk(8'h77, 2'b11, 4'h0);
    step();
    valid = 1'b0;
    step();
    check("sat.hold4", {28'd0, err_cnt4}, 32'hF);
    check("sat.cnt16b", {16'd0, err_cnt}, 32'd21);

    // mid-operation reset from TWO
    bready = 1'b0; valid = 1'b1; data = 14'h2AA1;
    step();
    data = 14'h2AA2;
    step();
    check("mid.two_ready", {31'd0, ready}, 32'd0);
    aresetn = 1'b0; valid = 1'b0;
    step();
    check("mid.rst_bvalid", {31'd0, bvalid},  32'd0);
    check("mid.rst_ready",  {31'd0, ready},   32'd0);
    check("mid.rst_errcnt", {16'd0, err_cnt}, 32'd0);
    check("mid.rst_bid",    {24'd0, bid},     32'd0);
    aresetn = 1'b1;
    step();
    check("mid.ready", {31'd0, ready}, 32'd1);
    bready = 1'b1;
    step();
    check("mid.nostale_a", {31'd0, bvalid}, 32'd0);
    step();
    check("mid.nostale_b", {31'd0, bvalid}, 32'd0);
    check("mid.errcnt4", {28'd0, err_cnt4}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
